// File: rtl/stopwatch_sequencer_if.sv
// stopwatch_sequencer_if: tick/switch inputs and count/status outputs of the stopwatch sequencer
interface stopwatch_sequencer_if #(parameter int CNT_W = 6);
   logic             tick_1hz;
   logic             tick_2hz;
   logic             ADJ;
   logic             SEL;
   logic             pause_p;
   logic             clear_p;
   logic [CNT_W-1:0] minutes;
   logic [CNT_W-1:0] seconds;
   logic             running;
   logic             adjusting;
   logic             rollover;
   logic             blink_min;
   logic             blink_sec;
   modport master (
      output tick_1hz, tick_2hz, ADJ, SEL, pause_p, clear_p,
      input  minutes, seconds, running, adjusting, rollover, blink_min, blink_sec
   );
   modport slave (
      input  tick_1hz, tick_2hz, ADJ, SEL, pause_p, clear_p,
      output minutes, seconds, running, adjusting, rollover, blink_min, blink_sec
   );
endinterface

// File: rtl/stopwatch_sequencer.sv
// stopwatch_sequencer: run/pause/adjust sequencing and mm:ss counting on tick enables.
// Define STOPWATCH_BLINK_EN to flash the field being adjusted at 1 Hz.
module stopwatch_sequencer #(
   parameter int SEC_MAX = 59,
   parameter int MIN_MAX = 59,
   parameter int CNT_W   = 6
) (
   input logic clk,
   input logic rst,
   stopwatch_sequencer_if.slave sw
);
   typedef enum logic [1:0] {PAUSED, RUN, ADJ_MIN, ADJ_SEC} state_t;
   state_t           state, state_n;
   logic             resume, resume_n;
   logic [CNT_W-1:0] min_q, sec_q, min_n, sec_n;
   logic             run_q, adj_q, roll_q, roll_n;
   logic             adj_now, adj_nxt, sec_top, min_top, run_cnt;
   always_comb begin
      adj_now  = state == ADJ_MIN || state == ADJ_SEC;
      state_n  = state;
      resume_n = resume;
      if (sw.ADJ) begin
         state_n  = sw.SEL ? ADJ_SEC : ADJ_MIN;
         resume_n = adj_now ? resume : state == RUN;
      end else if (adj_now)
         state_n = resume ? RUN : PAUSED;
      else if (sw.pause_p)
         state_n = state == RUN ? PAUSED : RUN;
      adj_nxt = state_n == ADJ_MIN || state_n == ADJ_SEC;
      sec_top = sec_q == CNT_W'(SEC_MAX);
      min_top = min_q == CNT_W'(MIN_MAX);
      // a tick in the cycle ADJ rises is swallowed: adjust wins over counting
      run_cnt = state == RUN && !sw.ADJ && sw.tick_1hz;
      sec_n   = sec_q;
      min_n   = min_q;
      roll_n  = 1'b0;
      if (run_cnt) begin
         sec_n  = sec_top ? '0 : sec_q + 1'b1;
         min_n  = !sec_top ? min_q : min_top ? '0 : min_q + 1'b1;
         roll_n = sec_top && min_top;
      end
      if (state == ADJ_MIN && sw.tick_2hz)
         min_n = min_top ? '0 : min_q + 1'b1;
      if (state == ADJ_SEC && sw.tick_2hz)
         sec_n = sec_top ? '0 : sec_q + 1'b1;
      if (sw.clear_p) begin
         sec_n  = '0;
         min_n  = '0;
         roll_n = 1'b0;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= PAUSED;
         resume <= 1'b0;
         min_q  <= '0;
         sec_q  <= '0;
         run_q  <= 1'b0;
         adj_q  <= 1'b0;
         roll_q <= 1'b0;
      end else begin
         state  <= state_n;
         resume <= resume_n;
         min_q  <= min_n;
         sec_q  <= sec_n;
         run_q  <= state_n == RUN;
         adj_q  <= adj_nxt;
         roll_q <= roll_n;
      end
   end
`ifdef STOPWATCH_BLINK_EN
   logic phase, phase_n, bmin_q, bsec_q;
   // phase restarts at 0 on every entry into adjust
   always_comb phase_n = adj_nxt && adj_now && (phase ^ sw.tick_2hz);
   always_ff @(posedge clk) begin
      if (rst) begin
         phase  <= 1'b0;
         bmin_q <= 1'b0;
         bsec_q <= 1'b0;
      end else begin
         phase  <= phase_n;
         bmin_q <= phase_n && state_n == ADJ_MIN;
         bsec_q <= phase_n && state_n == ADJ_SEC;
      end
   end
   assign sw.blink_min = bmin_q;
   assign sw.blink_sec = bsec_q;
`else
   assign sw.blink_min = 1'b0;
   assign sw.blink_sec = 1'b0;
`endif
   assign sw.minutes   = min_q;
   assign sw.seconds   = sec_q;
   assign sw.running   = run_q;
   assign sw.adjusting = adj_q;
   assign sw.rollover  = roll_q;
endmodule

// File: tb/tb_stopwatch_sequencer.sv
// tb_stopwatch_sequencer: scoreboard bench with a time-arithmetic reference model
module tb_stopwatch_sequencer;
   localparam int SMAX = 59;
   localparam int MMAX = 59;
   typedef struct packed {
      logic [5:0] mn;
      logic [5:0] sc;
      logic       run;
      logic       adj;
      logic       roll;
      logic       bm;
      logic       bs;
   } obs_t;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   stopwatch_sequencer_if #(.CNT_W(6)) sw ();
   stopwatch_sequencer #(.SEC_MAX(SMAX), .MIN_MAX(MMAX), .CNT_W(6)) dut (
      .clk(clk),
      .rst(rst),
      .sw(sw)
   );
   obs_t q[$];
   obs_t e_obs, g_obs;
   int   tests = 0;
   int   fails = 0;
   bit   adj_l = 1'b0;
   bit   sel_l = 1'b0;
   // mode: 0 paused, 1 running, 2 adjusting minutes, 3 adjusting seconds
   int   m_mode, m_min, m_sec;
   bit   m_res, m_roll, m_ph;
   task automatic model(input bit r, t1, t2, p, c);
      int  old, t;
      bit  was_adj;
      if (r) begin
         m_mode = 0; m_min = 0; m_sec = 0; m_res = 0; m_roll = 0; m_ph = 0;
         return;
      end
      old     = m_mode;
      was_adj = old >= 2;
      m_roll  = 0;
      if (old == 1 && !adj_l && t1) begin
         t      = m_min * (SMAX + 1) + m_sec + 1;
         m_roll = t == (MMAX + 1) * (SMAX + 1);
         t      = t % ((MMAX + 1) * (SMAX + 1));
         m_min  = t / (SMAX + 1);
         m_sec  = t % (SMAX + 1);
      end
      if (old == 2 && t2) m_min = (m_min + 1) % (MMAX + 1);
      if (old == 3 && t2) m_sec = (m_sec + 1) % (SMAX + 1);
      if (adj_l) begin
         if (!was_adj) m_res = old == 1;
         m_mode = sel_l ? 3 : 2;
      end else if (was_adj) m_mode = m_res ? 1 : 0;
      else if (p) m_mode = 1 - old;
      if (c) begin
         m_min = 0; m_sec = 0; m_roll = 0;
      end
      m_ph = (m_mode >= 2 && was_adj) ? m_ph ^ t2 : 1'b0;
   endtask
   task automatic step(input bit r, t1, t2, p, c);
      obs_t e;
      rst = r;
      sw.tick_1hz = t1; sw.tick_2hz = t2; sw.pause_p = p; sw.clear_p = c;
      sw.ADJ = adj_l; sw.SEL = sel_l;
      model(r, t1, t2, p, c);
      e.mn   = 6'(m_min);
      e.sc   = 6'(m_sec);
      e.run  = m_mode == 1;
      e.adj  = m_mode >= 2;
      e.roll = m_roll;
`ifdef STOPWATCH_BLINK_EN
      e.bm   = m_ph && m_mode == 2;
      e.bs   = m_ph && m_mode == 3;
`else
      e.bm   = 1'b0;
      e.bs   = 1'b0;
`endif
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
   endtask
   task automatic chk(input string name, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask
   always @(negedge clk) begin
      if (q.size() > 0) begin
         e_obs = q.pop_front();
         g_obs = {sw.minutes, sw.seconds, sw.running, sw.adjusting, sw.rollover, sw.blink_min, sw.blink_sec};
         tests++;
         if (g_obs !== e_obs) begin
            fails++;
            $display("FAIL scoreboard @%0t: got %0d:%0d run=%b adj=%b roll=%b bm=%b bs=%b expected %0d:%0d run=%b adj=%b roll=%b bm=%b bs=%b",
                     $time, g_obs.mn, g_obs.sc, g_obs.run, g_obs.adj, g_obs.roll, g_obs.bm, g_obs.bs,
                     e_obs.mn, e_obs.sc, e_obs.run, e_obs.adj, e_obs.roll, e_obs.bm, e_obs.bs);
         end
      end
   end
   initial begin
      bit prev;
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      chk("reset_min", sw.minutes, 0);
      chk("reset_run", sw.running, 0);
      step(0, 0, 0, 1, 0);
      for (int i = 0; i < 61; i++) begin
         step(0, 1, 0, 0, 0);
         idle(2);
      end
      chk("61t_min", sw.minutes, 1);
      chk("61t_sec", sw.seconds, 1);
      chk("61t_run", sw.running, 1);
      step(0, 0, 0, 0, 1);
      adj_l = 1; sel_l = 0;
      idle(1);
      for (int i = 0; i < 59; i++) step(0, 0, 1, 0, 0);
      sel_l = 1;
      idle(1);
      for (int i = 0; i < 58; i++) step(0, 0, 1, 0, 0);
      adj_l = 0;
      idle(1);
      chk("preload_min", sw.minutes, 59);
      chk("preload_sec", sw.seconds, 58);
      chk("resume_run", sw.running, 1);
      step(0, 1, 0, 0, 0);
      chk("roll_early", sw.rollover, 0);
      step(0, 1, 0, 0, 0);
      chk("roll_hi", sw.rollover, 1);
      chk("roll_min", sw.minutes, 0);
      chk("roll_sec", sw.seconds, 0);
      idle(1);
      chk("roll_lo", sw.rollover, 0);
      for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0);
      for (int k = 0; k < 2; k++) begin
         adj_l = 1; sel_l = 1;
         step(0, 1, 0, 0, 0);
         for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0);
         for (int i = 0; i < 2; i++) step(0, 1, 0, 0, 0);
         chk("adjsec_sec", sw.seconds, k == 0 ? 13 : 16);
         chk("adjsec_min", sw.minutes, 0);
         chk("adjsec_adj", sw.adjusting, 1);
         adj_l = 0;
         idle(1);
         chk("adj_resume", sw.running, k == 0 ? 1 : 0);
         chk("adj_exit", sw.adjusting, 0);
         if (k == 0) step(0, 0, 0, 1, 0);
      end
      adj_l = 1; sel_l = 0;
      idle(1);
      for (int i = 0; i < 59; i++) step(0, 0, 1, 0, 0);
      chk("adjmin_59", sw.minutes, 59);
      step(0, 0, 1, 0, 0);
      chk("adjmin_wrap", sw.minutes, 0);
      chk("adjmin_sec", sw.seconds, 16);
      chk("adjmin_roll", sw.rollover, 0);
      for (int i = 0; i < 4; i++) begin
         prev = sw.blink_min;
         step(0, 0, 1, 0, 0);
`ifdef STOPWATCH_BLINK_EN
         chk("blink_min", sw.blink_min, !prev);
`else
         chk("blink_min", sw.blink_min, 0);
`endif
         chk("blink_sec", sw.blink_sec, 0);
      end
      adj_l = 0;
      idle(1);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 1);
      adj_l = 1; sel_l = 0;
      idle(1);
      for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0);
      sel_l = 1;
      idle(1);
      for (int i = 0; i < 30; i++) step(0, 0, 1, 0, 0);
      adj_l = 0;
      idle(1);
      chk("preset_min", sw.minutes, 5);
      chk("preset_sec", sw.seconds, 30);
      step(0, 1, 0, 0, 1);
      chk("clr_min", sw.minutes, 0);
      chk("clr_sec", sw.seconds, 0);
      chk("clr_run", sw.running, 1);
      adj_l = 1; sel_l = 1;
      idle(1);
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      step(1, 0, 1, 0, 0);
      chk("rst_sec", sw.seconds, 0);
      chk("rst_run", sw.running, 0);
      chk("rst_adj", sw.adjusting, 0);
      adj_l = 0;
      idle(2);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(39) == 0) adj_l = !adj_l;
         if ($urandom_range(9) == 0) sel_l = !sel_l;
         step($urandom_range(499) == 0, $urandom_range(2) == 0, $urandom_range(3) == 0,
              $urandom_range(24) == 0, $urandom_range(149) == 0);
      end
      adj_l = 0;
      idle(3);
      @(negedge clk);
      #1;
      chk("drain", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
